tlut_result_drain: RTL and testbench
====================================

Name: tlut_result_drain

Overview:
- Downstream stage of the TLUT SIMD cell.
- Captures each completed `DIM_MULT`-wide accumulated product vector when the upstream pass finishes, and holds the vectors in a small frame FIFO.
- Serialises the vectors element by element onto a valid/ready stream.
- Raises `full` so the sequencer can deassert the cell's `enable` until space frees.

Parameters:
- DIM_MULT, 4, number of accumulated products per frame (matches `DIM_MULT`).
- ACC_WIDTH, 16, width of each accumulated product (matches `ACC_WIDTH`).
- DEPTH, 2, number of frames buffered; power of two, at least 2.
- IDX_W, $clog2(DIM_MULT), width of the element index.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous clear of FIFO contents; `overflow` is kept.
- capture  in  1  one-cycle pulse: `accumulated_mult` holds a finished frame this cycle.
- accumulated_mult  in  DIM_MULT*ACC_WIDTH  product vector from the adder tree; element i is at [i].
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- out_data  out  ACC_WIDTH  current element of the head frame.
- out_index  out  IDX_W  element number of `out_data` within its frame.
- out_last  out  1  high with the final element (index DIM_MULT-1) of a frame.
- full  out  1  occupancy == DEPTH.
- count  out  CNT_W  number of frames stored, including a partially drained head frame.
- overflow  out  1  sticky flag: a capture was dropped.

Behaviour:
- Reset (rst=1 at an edge):
  - write pointer, read pointer, `count` and element index go to 0.
  - `out_valid`=0, `out_last`=0, `full`=0, `overflow`=0.
  - `out_data` and `out_index` are 0 while `out_valid`=0.
  - Frame storage contents are not reset.
  - Reset mid-drain discards every frame, including a partially sent one.
- Flush: same as reset, except `overflow` keeps its value. Flush takes priority over a capture or handshake in the same cycle.
- Capture (write):
  - When capture=1 and the FIFO is not full, or a frame pop happens in the same cycle, the entire vector is written to the frame at the write pointer.
  - The write pointer then increments modulo DEPTH.
- Dropped capture:
  - capture=1 while full=1 with no same-cycle pop: the frame is dropped.
  - `overflow` is set the next cycle and stays set until rst.
  - Stored data is not changed.
- Latency: a frame captured into an empty FIFO gives out_valid=1 on the next cycle, with index 0.
- Output data:
  - `out_data` = head frame element [`out_index`], driven from registered pointers and storage.
  - `out_valid` = (count != 0).
- Handshake:
  - A transfer occurs when out_valid && out_ready. The index then increments.
  - `out_data`, `out_index` and `out_last` must stay stable while out_valid && !out_ready.
  - `out_valid` never drops without a transfer, except on rst or flush.
- Frame pop:
  - A transfer with out_last=1 resets the index to 0, increments the read pointer modulo DEPTH, and decrements `count`.
  - The next frame, if present, is presented on the following cycle with no bubble.
- Simultaneous capture and pop: `count` is unchanged. If the FIFO was full, the capture is accepted (no overflow) and `full` stays 1.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0; occupancy is tracked by `count`, not by pointer compare.
- Width rules: element values pass through unmodified with no sign or width change. `out_index` counts 0..DIM_MULT-1 and never reaches DIM_MULT.
- State:
  - The drain sequencer is implicit in (count, index), with two states: IDLE (count=0) and SEND (count>0).
  - SEND returns to IDLE only on a last-element pop that brings count to 0 with no same-cycle capture.
- `full` is registered-consistent with `count`; it is not look-ahead.

Test Plan:
- Single frame, ready tied high:
  - Stimulus: rst, then capture with vector {0x0004,0x0003,0x0002,0x0001} (element0=0x0001).
  - Response: out_valid rises 1 cycle later; out_data is 0x0001,0x0002,0x0003,0x0004 on consecutive cycles with index 0..3; out_last only on 0x0004; then out_valid=0 and count=0.
- Back-pressure:
  - Stimulus: as above, but out_ready=0 for 3 cycles after out_valid rises, then 1.
  - Response: out_data holds at 0x0001 with index 0 for all 3 cycles; no element is skipped or repeated.
- Fill and overflow:
  - Stimulus: out_ready=0; capture frames A, B, C on consecutive cycles.
  - Response: count=2 and full=1 after B; C is dropped and overflow=1 the cycle after; draining yields only A then B.
- Capture during pop:
  - Stimulus: full with A and B, out_ready=1; capture C in the cycle A's last element transfers.
  - Response: C is accepted, overflow stays 0, full stays 1; the stream is A0..A3, B0..B3, C0..C3 with no gaps.
- Flush and reset mid-drain:
  - Stimulus: with overflow=1, assert flush after 2 elements of A; later assert rst.
  - Response: after flush, out_valid=0, count=0, overflow still 1, and the next capture streams from index 0. After rst, overflow=0.

Source files
------------

// File: rtl/tlut_result_drain.sv
// Frame FIFO behind the TLUT SIMD cell: captures finished product vectors and
// serialises them element by element onto a valid/ready stream.
module tlut_result_drain #(
  parameter int DIM_MULT  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int DEPTH     = 2,
  parameter int IDX_W     = $clog2(DIM_MULT),
  parameter int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          capture,
  input  logic [DIM_MULT*ACC_WIDTH-1:0] accumulated_mult,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last,
  output logic                          full,
  output logic [CNT_W-1:0]              count,
  output logic                          overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DIM_MULT*ACC_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]              r_wptr, r_rptr;
  logic [CNT_W-1:0]              r_count;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_ovf;

  logic [DIM_MULT*ACC_WIDTH-1:0] w_head;
  logic [ACC_WIDTH-1:0]          w_elem [DIM_MULT];
  logic                          w_valid, w_last, w_full;
  logic                          w_xfer, w_pop, w_wr, w_drop;

  assign w_head = r_mem[r_rptr];
  for (genvar g = 0; g < DIM_MULT; g++) begin : g_elem
    assign w_elem[g] = w_head[g*ACC_WIDTH +: ACC_WIDTH];
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_last  = w_valid && (r_idx == IDX_W'(DIM_MULT-1));
  assign w_xfer  = w_valid && out_ready;
  assign w_pop   = w_xfer && w_last;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_wr    = capture && (!w_full || w_pop);
  assign w_drop  = capture && w_full && !w_pop;

  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_elem[r_idx] : '0;
  assign out_index = w_valid ? r_idx : '0;
  assign out_last  = w_last;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_ovf;

  // Storage carries no reset; stale slots are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr)
      r_mem[r_wptr] <= accumulated_mult;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      if (rst) r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_xfer) r_idx <= w_pop ? '0 : r_idx + IDX_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tlut_result_drain.sv
// Directed bench for tlut_result_drain: streaming, back-pressure, overflow,
// capture-during-pop, flush and reset.
module tb_tlut_result_drain;
  logic        clk = 1'b0;
  logic        rst, flush, capture, out_ready;
  logic [63:0] accumulated_mult;
  logic        out_valid, out_last, full, overflow;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic [1:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  tlut_result_drain #(.DIM_MULT(4), .ACC_WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .capture(capture),
    .accumulated_mult(accumulated_mult), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] vec(input logic [15:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  // Expects the given frame to stream with ready high, one element per cycle.
  task automatic drain_frame(input string tag, input logic [63:0] v);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, 64'(out_valid), 64'(1));
      chk({tag, "_data"},  64'(out_data),  64'(v[i*16 +: 16]));
      chk({tag, "_index"}, 64'(out_index), 64'(i));
      chk({tag, "_last"},  64'(out_last),  64'(i == 3));
      tick();
    end
  endtask

  task automatic cap(input logic [63:0] v);
    capture = 1'b1;
    accumulated_mult = v;
    tick();
    capture = 1'b0;
  endtask

  logic [63:0] va, vb, vc, vd;

  initial begin
    va = vec(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    vb = vec(16'hB000, 16'hB111, 16'hFFFF, 16'h8000);
    vc = vec(16'hC0DE, 16'h0000, 16'h7FFF, 16'h1234);
    vd = vec(16'hD001, 16'hD002, 16'hD003, 16'hD004);
    rst = 1'b1; flush = 1'b0; capture = 1'b0; out_ready = 1'b0;
    accumulated_mult = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_full",  64'(full), 0);
    chk("rst_ovf",   64'(overflow), 0);
    chk("rst_data",  64'(out_data), 0);
    chk("rst_index", 64'(out_index), 0);
    chk("rst_last",  64'(out_last), 0);

    // single frame, ready high
    out_ready = 1'b1;
    cap(va);
    chk("t1_count", 64'(count), 1);
    drain_frame("t1", va);
    chk("t1_idle_valid", 64'(out_valid), 0);
    chk("t1_idle_count", 64'(count), 0);

    // back-pressure for 3 cycles
    out_ready = 1'b0;
    cap(va);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_data",  64'(out_data), 64'h0001);
      chk("bp_index", 64'(out_index), 0);
      tick();
    end
    out_ready = 1'b1;
    drain_frame("bp", va);
    chk("bp_idle", 64'(out_valid), 0);

    // fill and overflow
    out_ready = 1'b0;
    cap(va);
    cap(vb);
    chk("fill_count", 64'(count), 2);
    chk("fill_full",  64'(full), 1);
    chk("fill_ovf0",  64'(overflow), 0);
    cap(vc);
    chk("ovf_set",   64'(overflow), 1);
    chk("ovf_count", 64'(count), 2);
    out_ready = 1'b1;
    drain_frame("ovfA", va);
    drain_frame("ovfB", vb);
    chk("ovf_idle", 64'(out_valid), 0);
    chk("ovf_sticky", 64'(overflow), 1);

    // flush mid-drain keeps overflow
    cap(va);
    tick(); tick();
    chk("pre_flush_index", 64'(out_index), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_count", 64'(count), 0);
    chk("fl_ovf",   64'(overflow), 1);
    chk("fl_index", 64'(out_index), 0);
    cap(vd);
    drain_frame("flD", vd);

    // reset mid-drain clears overflow
    cap(vd);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_ovf",   64'(overflow), 0);
    chk("rs_valid", 64'(out_valid), 0);
    chk("rs_count", 64'(count), 0);
    chk("rs_full",  64'(full), 0);

    // capture during pop while full
    out_ready = 1'b0;
    cap(va);
    cap(vb);
    chk("cp_full", 64'(full), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("cpA_data", 64'(out_data), 64'(va[i*16 +: 16]));
      tick();
    end
    chk("cpA_last", 64'(out_last), 1);
    chk("cpA_data3", 64'(out_data), 64'h0004);
    cap(vc);
    chk("cp_ovf",   64'(overflow), 0);
    chk("cp_full2", 64'(full), 1);
    chk("cp_count", 64'(count), 2);
    drain_frame("cpB", vb);
    drain_frame("cpC", vc);
    chk("cp_idle", 64'(out_valid), 0);
    chk("cp_count0", 64'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
